// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state encoding, response codes and helpers for the
// APB-to-register bridge.
package apb_bridge_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Response codes; anything other than RESP_OKAY is reported as PSLVERR.
  typedef logic [2:0] resp_t;
  localparam resp_t RESP_OKAY  = 3'd0;
  localparam resp_t ERR_DECODE = 3'd1;
  localparam resp_t ERR_RO     = 3'd2;
  localparam resp_t ERR_SLAVE  = 3'd3;
  localparam resp_t ERR_TMO    = 3'd4;

  // Width of a register index; at least one bit even for a single register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// apb_reg_decode: combinational APB address -> register index decode.
// hit  : word-aligned address inside the NREG-word window at BASE_ADDR
// index: register number (valid only with hit)
// ro   : register is marked read-only in RO_MASK (valid only with hit)
module apb_reg_decode #(
  parameter int              AWIDTH    = 8,
  parameter int              NREG      = 6,
  parameter logic [31:0]     BASE_ADDR = 32'h0,
  parameter logic [NREG-1:0] RO_MASK   = '0,
  parameter int              IW        = 3
) (
  input  logic [AWIDTH-1:0] addr,
  output logic              hit,
  output logic [IW-1:0]     index,
  output logic              ro
);

  // Word offset from the window base; wraps for addresses below the base,
  // which then fall outside the window.
  logic [AWIDTH-3:0] word;

  assign word  = addr[AWIDTH-1:2] - BASE_ADDR[AWIDTH-1:2];
  assign hit   = (addr[1:0] == 2'b00) && (32'(word) < 32'(NREG));
  assign index = word[IW-1:0];
  assign ro    = hit && RO_MASK[index];

endmodule

// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB slave that decodes NREG word registers and hands each
// access to a register file as a one-cycle request pulse, completing the APB
// transfer once the register file acks.
// Optional feature: define APB_TIMEOUT_EN to terminate unacked accesses with
// PSLVERR after TMO_CYCLES cycles; without it WAIT lasts until ack or abort.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an APB setup phase; decode captured on entry out
// REQ     | single-cycle rreq_o/wreq_o pulse; a same-cycle ack is allowed
// WAIT    | request issued, waiting for the matching ack (or timeout)
// RESP    | apb_ready_o high for one cycle with apb_err_o/apb_rdata_o
module apb_reg_bridge
  import apb_bridge_pkg::*;
#(
  parameter int              AWIDTH     = 8,
  parameter int              DWIDTH     = 32,
  parameter int              NREG       = 6,
  parameter logic [31:0]     BASE_ADDR  = 32'h0,
  parameter logic [NREG-1:0] RO_MASK    = '0,
  parameter int              TMO_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AWIDTH-1:0]   apb_addr_i,
  input  logic                apb_sel_i,
  input  logic                apb_en_i,
  input  logic                apb_wr_i,
  input  logic [DWIDTH-1:0]   apb_wdata_i,
  input  logic [DWIDTH/8-1:0] apb_strb_i,
  output logic [DWIDTH-1:0]   apb_rdata_o,
  output logic                apb_ready_o,
  output logic                apb_err_o,
  output logic [NREG-1:0]     rreq_o,
  input  logic [DWIDTH-1:0]   rdat_i,
  input  logic                rack_i,
  input  logic                rerr_i,
  output logic [NREG-1:0]     wreq_o,
  output logic [DWIDTH-1:0]   wdat_o,
  output logic [DWIDTH/8-1:0] wstr_o,
  input  logic                wack_i,
  input  logic                werr_i
);

  localparam int              IW  = idx_width(NREG);
  localparam logic [NREG-1:0] ONE = NREG'(1);

  state_e              state_q, state_nxt;
  resp_t               resp_q, resp_nxt;
  logic [DWIDTH-1:0]   rdata_nxt;
  logic                dec_hit, dec_ro;
  logic [IW-1:0]       dec_idx;
  logic                wr_q;
  logic                load_setup;
  logic                ack, ack_err;
  logic                tmo_hit;

  apb_reg_decode #(
    .AWIDTH   (AWIDTH),
    .NREG     (NREG),
    .BASE_ADDR(BASE_ADDR),
    .RO_MASK  (RO_MASK),
    .IW       (IW)
  ) u_decode (
    .addr (apb_addr_i),
    .hit  (dec_hit),
    .index(dec_idx),
    .ro   (dec_ro)
  );

  // Only the ack matching the captured direction completes a transfer.
  assign ack     = wr_q ? wack_i : rack_i;
  assign ack_err = wr_q ? werr_i : rerr_i;

  // resp_q is OKAY outside RESP, so PSLVERR is only ever seen with PREADY.
  assign apb_err_o = (resp_q != RESP_OKAY);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;

  // Counts unacked REQ/WAIT cycles; restarted by every accepted setup phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (load_setup) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_REQ || state_q == ST_WAIT) && !ack) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose missing ack brings the count to TMO_CYCLES.
  assign tmo_hit = (tmo_cnt_q == CW'(TMO_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, response code and read data selection.
  always_comb begin
    state_nxt  = state_q;
    resp_nxt   = RESP_OKAY;
    rdata_nxt  = apb_rdata_o;
    load_setup = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (apb_sel_i && !apb_en_i) begin
          load_setup = 1'b1;
          if (!dec_hit) begin
            state_nxt = ST_RESP;
            resp_nxt  = ERR_DECODE;
            rdata_nxt = '0;
          end else if (apb_wr_i && dec_ro) begin
            state_nxt = ST_RESP;
            resp_nxt  = ERR_RO;
            rdata_nxt = '0;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        if (!apb_sel_i) begin
          state_nxt = ST_IDLE;
        end else if (ack) begin
          state_nxt = ST_RESP;
          resp_nxt  = ack_err ? ERR_SLAVE : RESP_OKAY;
          rdata_nxt = (!wr_q && !ack_err) ? rdat_i : '0;
        end else if (tmo_hit) begin
          state_nxt = ST_RESP;
          resp_nxt  = ERR_TMO;
          rdata_nxt = '0;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, captured access and registered APB/register-file outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      resp_q      <= RESP_OKAY;
      wr_q        <= 1'b0;
      wdat_o      <= '0;
      wstr_o      <= '0;
      apb_ready_o <= 1'b0;
      apb_rdata_o <= '0;
      rreq_o      <= '0;
      wreq_o      <= '0;
    end else begin
      state_q     <= state_nxt;
      resp_q      <= resp_nxt;
      apb_ready_o <= (state_nxt == ST_RESP);
      apb_rdata_o <= rdata_nxt;
      if (load_setup) begin
        wr_q   <= apb_wr_i;
        wdat_o <= apb_wdata_i;
        wstr_o <= apb_strb_i;
      end
      // REQ is only entered from IDLE, so the live decode is the one to pulse.
      rreq_o <= (state_nxt == ST_REQ && !apb_wr_i) ? (ONE << dec_idx) : '0;
      wreq_o <= (state_nxt == ST_REQ &&  apb_wr_i) ? (ONE << dec_idx) : '0;
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge: randomized and directed APB transfers against a
// transfer-level reference model of the bridge.
`timescale 1ns/1ps
module tb_apb_reg_bridge;

  localparam int             AW  = 8;
  localparam int             DW  = 32;
  localparam int             NR  = 6;
  localparam int             TMO = 16;
  localparam logic [NR-1:0]  RO  = 6'b000100;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] apb_addr;
  logic          apb_sel, apb_en, apb_wr;
  logic [DW-1:0] apb_wdata;
  logic [3:0]    apb_strb;
  logic [DW-1:0] apb_rdata;
  logic          apb_ready, apb_err;
  logic [NR-1:0] rreq, wreq;
  logic [DW-1:0] rdat;
  logic          rack, rerr;
  logic [DW-1:0] wdat;
  logic [3:0]    wstr;
  logic          wack, werr;

  int            n_run  = 0;
  int            n_fail = 0;
  logic [DW-1:0] rdata_hold;

  apb_reg_bridge #(
    .AWIDTH(AW), .DWIDTH(DW), .NREG(NR), .BASE_ADDR(32'h0),
    .RO_MASK(RO), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .apb_addr_i(apb_addr), .apb_sel_i(apb_sel), .apb_en_i(apb_en),
    .apb_wr_i(apb_wr), .apb_wdata_i(apb_wdata), .apb_strb_i(apb_strb),
    .apb_rdata_o(apb_rdata), .apb_ready_o(apb_ready), .apb_err_o(apb_err),
    .rreq_o(rreq), .rdat_i(rdat), .rack_i(rack), .rerr_i(rerr),
    .wreq_o(wreq), .wdat_o(wdat), .wstr_o(wstr),
    .wack_i(wack), .werr_i(werr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete APB transfer. The model predicts, from the protocol rules,
  // the cycle (counted from the setup cycle) in which PREADY appears, the
  // response, and the request pulse. delay = ack cycles after the request
  // cycle; abort_at > 0 drops PSEL in that cycle.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input logic [3:0] strb,
                         input int delay, input logic serr,
                         input logic [DW-1:0] rd, input int abort_at,
                         input string name);
    int            idx, exp_k, limit, got_k, rreq_k, wreq_k, n_rq, n_wq;
    bit            legal, tmo, exp_err;
    logic [DW-1:0] exp_rd, got_rd, wd_v;
    logic [3:0]    ws_v;
    logic [NR-1:0] exp_oh, rq_v, wq_v;
    logic          got_err;
    idx   = int'(addr) / 4;
    legal = (addr % 4 == 0) && (idx < NR);
    if (legal && wr && RO[idx]) legal = 0;
    exp_oh = '0;
    if (legal) exp_oh[idx] = 1'b1;
    tmo = 0;
`ifdef APB_TIMEOUT_EN
    if (legal && delay >= TMO) tmo = 1;
`endif
    if (!legal)            exp_k = 1;
    else if (abort_at > 0) exp_k = 0;
    else if (tmo)          exp_k = TMO + 1;
    else                   exp_k = delay + 2;
    exp_err = !legal || tmo || serr;
    exp_rd  = (legal && !wr && !serr && !tmo) ? rd : '0;
    limit   = (exp_k == 0) ? delay + 6 : exp_k + 2;

    // setup phase
    apb_sel = 1; apb_en = 0; apb_addr = addr; apb_wr = wr;
    apb_wdata = wdata; apb_strb = strb;
    rack = 0; wack = 0;
    @(negedge clk);
    n_run++;
    if (apb_ready !== 0 || apb_err !== 0 || rreq !== 0 || wreq !== 0 || apb_rdata !== rdata_hold) begin
      n_fail++;
      $display("FAIL %s idle-before-setup: ready=%b err=%b rreq=%b wreq=%b rdata=%h, required 0 0 0 0 rdata=%h",
               name, apb_ready, apb_err, rreq, wreq, apb_rdata, rdata_hold);
    end
    @(posedge clk); #1;

    got_k = 0; rreq_k = 0; wreq_k = 0; n_rq = 0; n_wq = 0;
    got_err = 0; got_rd = '0; rq_v = '0; wq_v = '0; wd_v = '0; ws_v = '0;
    for (int k = 1; k <= limit && got_k == 0; k++) begin
      apb_en = 1;
      if (abort_at > 0 && k >= abort_at) begin apb_sel = 0; apb_en = 0; end
      rdat = (k == delay + 1) ? rd : $urandom;
      if (wr) begin
        wack = (k == delay + 1);
        werr = (k == delay + 1) ? serr : 1'($urandom);
        rack = 1'($urandom); rerr = 1'($urandom);
      end else begin
        rack = (k == delay + 1);
        rerr = (k == delay + 1) ? serr : 1'($urandom);
        wack = 1'($urandom); werr = 1'($urandom);
      end
      @(negedge clk);
      if (rreq !== '0) begin n_rq++; rreq_k = k; rq_v = rreq; end
      if (wreq !== '0) begin n_wq++; wreq_k = k; wq_v = wreq; wd_v = wdat; ws_v = wstr; end
      if (apb_ready === 1'b1) begin got_k = k; got_err = apb_err; got_rd = apb_rdata; end
      @(posedge clk); #1;
    end
    apb_sel = 0; apb_en = 0; rack = 0; wack = 0; rerr = 0; werr = 0;

    n_run++;
    if (got_k != exp_k) begin
      n_fail++;
      $display("FAIL %s ready-cycle: got %0d, required %0d (0 = none)", name, got_k, exp_k);
    end
    if (exp_k > 0 && got_k > 0) begin
      n_run++;
      if (got_err !== exp_err || got_rd !== exp_rd) begin
        n_fail++;
        $display("FAIL %s response: err=%b rdata=%h, required err=%b rdata=%h",
                 name, got_err, got_rd, exp_err, exp_rd);
      end
    end
    n_run++;
    if (n_rq != ((legal && !wr) ? 1 : 0) || (n_rq == 1 && (rreq_k != 1 || rq_v !== exp_oh))) begin
      n_fail++;
      $display("FAIL %s rreq: pulses=%0d cycle=%0d value=%b, required pulses=%0d cycle=1 value=%b",
               name, n_rq, rreq_k, rq_v, (legal && !wr) ? 1 : 0, exp_oh);
    end
    n_run++;
    if (n_wq != ((legal && wr) ? 1 : 0) ||
        (n_wq == 1 && (wreq_k != 1 || wq_v !== exp_oh || wd_v !== wdata || ws_v !== strb))) begin
      n_fail++;
      $display("FAIL %s wreq: pulses=%0d cycle=%0d value=%b wdat=%h wstr=%h, required pulses=%0d cycle=1 value=%b wdat=%h wstr=%h",
               name, n_wq, wreq_k, wq_v, wd_v, ws_v, (legal && wr) ? 1 : 0, exp_oh, wdata, strb);
    end
    if (exp_k > 0) rdata_hold = exp_rd;
  endtask

  // Idle cycles with PSEL low and random ack/err noise that must be ignored.
  task automatic idle_noise(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      apb_sel = 0; apb_en = 0;
      rack = 1'($urandom); wack = 1'($urandom);
      rerr = 1'($urandom); werr = 1'($urandom); rdat = $urandom;
      @(negedge clk);
      n_run++;
      if (apb_ready !== 0 || apb_err !== 0 || rreq !== 0 || wreq !== 0 || apb_rdata !== rdata_hold) begin
        n_fail++;
        $display("FAIL %s idle: ready=%b err=%b rreq=%b wreq=%b rdata=%h, required 0 0 0 0 rdata=%h",
                 name, apb_ready, apb_err, rreq, wreq, apb_rdata, rdata_hold);
      end
      @(posedge clk); #1;
    end
    rack = 0; wack = 0; rerr = 0; werr = 0;
  endtask

  task automatic test_reset();
    rst = 1; apb_sel = 0; apb_en = 0; apb_wr = 0; apb_addr = '0;
    apb_wdata = '0; apb_strb = '0; rdat = '0; rack = 0; rerr = 0; wack = 0; werr = 0;
    rdata_hold = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (apb_ready !== 0 || apb_err !== 0 || apb_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset apb: ready=%b err=%b rdata=%h, required all 0", apb_ready, apb_err, apb_rdata);
    end
    n_run++;
    if (rreq !== '0 || wreq !== '0 || wdat !== '0 || wstr !== '0) begin
      n_fail++;
      $display("FAIL reset regfile: rreq=%b wreq=%b wdat=%h wstr=%h, required all 0", rreq, wreq, wdat, wstr);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_directed();
    do_xfer(8'h0C, 1, 32'hA5A5_0001, 4'hF, 0, 0, '0, 0, "wr_0c_zero_wait");
    do_xfer(8'h08, 1, 32'hA5A5_0001, 4'hF, 0, 0, '0, 0, "wr_ro_reg2");
    do_xfer(8'h08, 0, '0, 4'h0, 0, 0, 32'h0000_BEEF, 0, "rd_ro_reg2");
    do_xfer(8'h04, 0, '0, 4'h0, 3, 0, 32'h0000_1234, 0, "rd_04_wait3");
    do_xfer(8'h18, 0, '0, 4'h0, 0, 0, 32'h1111_1111, 0, "rd_out_of_range");
    do_xfer(8'h05, 0, '0, 4'h0, 0, 0, 32'h2222_2222, 0, "rd_unaligned");
    do_xfer(8'h14, 1, 32'h0BAD_F00D, 4'h5, 1, 0, '0, 0, "wr_last_reg");
    do_xfer(8'h14, 0, '0, 4'h0, 2, 0, 32'h7777_0001, 0, "rd_last_reg");
  endtask

  task automatic test_slave_err();
    do_xfer(8'h00, 0, '0, 4'h0, 1, 1, 32'hFFFF_FFFF, 0, "rd_slave_err");
    do_xfer(8'h10, 1, 32'h1234_5678, 4'h3, 0, 1, '0, 0, "wr_slave_err");
  endtask

  task automatic test_abort();
    do_xfer(8'h0C, 0, '0, 4'h0, 1, 0, 32'hCAFE_0003, 0, "rd_before_abort");
    do_xfer(8'h0C, 0, '0, 4'h0, 5, 0, 32'hDEAD_0000, 2, "rd_abort_wait");
    do_xfer(8'h10, 1, 32'h5555_AAAA, 4'hF, 4, 0, '0, 3, "wr_abort_wait");
    do_xfer(8'h0C, 0, '0, 4'h0, 1, 0, 32'h0000_0C0C, 0, "rd_after_abort");
  endtask

  task automatic test_idle_acks();
    idle_noise(4, "acks_in_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_xfer(AW'($urandom_range(0, 5) * 4), 1'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 2), 0, $urandom, 0, "back_to_back");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = 8'hFC;
      do_xfer(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 5) == 0), $urandom, 0, "random");
      if ($urandom_range(0, 2) == 0) idle_noise($urandom_range(1, 2), "random_gap");
    end
  endtask

  task automatic test_mid_reset();
    do_xfer(8'h04, 0, '0, 4'h0, 0, 0, 32'h4444_0004, 0, "rd_before_reset");
    apb_sel = 1; apb_en = 0; apb_wr = 0; apb_addr = 8'h0C;
    apb_wdata = 32'hDEAD_BEEF; apb_strb = 4'hF; rack = 0; wack = 0;
    @(posedge clk); #1;
    apb_en = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; apb_sel = 0; apb_en = 0;
    rdata_hold = '0;
    @(negedge clk);
    n_run++;
    if (apb_ready !== 0 || apb_err !== 0 || rreq !== '0 || wreq !== '0 ||
        apb_rdata !== '0 || wdat !== '0 || wstr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b err=%b rreq=%b wreq=%b rdata=%h wdat=%h wstr=%h, required all 0",
               apb_ready, apb_err, rreq, wreq, apb_rdata, wdat, wstr);
    end
    @(posedge clk); #1;
    idle_noise(2, "late_ack_after_reset");
    do_xfer(8'h0C, 0, '0, 4'h0, 1, 0, 32'h0C0C_0C0C, 0, "rd_after_reset");
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    do_xfer(8'h00, 0, '0, 4'h0, 100, 0, 32'h9999_9999, 0, "rd_timeout");
    idle_noise(2, "late_ack_after_timeout");
    do_xfer(8'h10, 1, 32'h0F0F_0F0F, 4'hF, TMO - 1, 0, '0, 0, "wr_ack_at_timeout");
    do_xfer(8'h04, 0, '0, 4'h0, TMO, 0, 32'h8888_8888, 0, "rd_ack_after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_slave_err();
    test_abort();
    test_idle_acks();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
